// File: rtl/frame_timer_pkg.sv
// Shared encodings for the multi-channel frame timer.
// Mode, write-kind and channel state codes used by the top level and the channel slice.
package frame_timer_pkg;

  typedef enum logic {
    FT_ONE_SHOT    = 1'b0,
    FT_AUTO_RELOAD = 1'b1
  } ft_mode_e;

  typedef enum logic [1:0] {
    FT_WR_RELOAD = 2'b00,
    FT_WR_MODE   = 2'b01,
    FT_WR_PRESC  = 2'b10,
    FT_WR_NONE   = 2'b11
  } ft_wr_kind_e;

  typedef enum logic {
    FT_IDLE = 1'b0,
    FT_RUN  = 1'b1
  } ft_state_e;

  // Index width that stays at least one bit wide, so single-entry selects remain legal ports.
  function automatic int ft_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_timer_ch.sv
// One timer channel: byte-loaded reload buffer, mode bit, count register and IDLE/RUN FSM.
// Start beats stop, and stop beats a prescaler step.
module frame_timer_ch
  import frame_timer_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int DATA_W = 8,
  parameter int BYTE_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_reload,
  input  logic [BYTE_W-1:0] i_wr_byte,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_mode,
  input  logic              i_mode_bit,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_pause,
  input  logic              i_step,
  output logic [CNT_W-1:0]  o_cnt,
  output logic              o_active,
  output logic              o_tick
);

  localparam int NBYTES = CNT_W / DATA_W;

  logic [CNT_W-1:0] r_reload;
  logic [CNT_W-1:0] r_cnt;
  ft_mode_e         r_mode;
  ft_state_e        r_state;
  logic             r_tick;

  // Start reads r_reload before this cycle's byte write lands, so a colliding write is not seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reload <= '0;
      r_cnt    <= '0;
      r_mode   <= FT_ONE_SHOT;
      r_state  <= FT_IDLE;
      r_tick   <= 1'b0;
    end else begin
      r_tick <= 1'b0;

      if (i_wr_reload) begin
        for (int b = 0; b < NBYTES; b++) begin
          if (i_wr_byte == BYTE_W'(b)) begin
            r_reload[b*DATA_W +: DATA_W] <= i_wr_data;
          end
        end
      end

      if (i_wr_mode) begin
        r_mode <= ft_mode_e'(i_mode_bit);
      end

      if (i_start) begin
        if (r_reload != '0) begin
          r_cnt   <= r_reload;
          r_state <= FT_RUN;
        end else begin
          r_cnt   <= '0;
          r_state <= FT_IDLE;
        end
      end else if (i_stop) begin
        r_cnt   <= '0;
        r_state <= FT_IDLE;
      end else if (r_state == FT_RUN && i_step && !i_pause) begin
        if (r_cnt > CNT_W'(1)) begin
          r_cnt <= r_cnt - CNT_W'(1);
        end else begin
          r_tick <= 1'b1;
          if (r_mode == FT_AUTO_RELOAD && r_reload != '0) begin
            r_cnt <= r_reload;
          end else begin
            r_cnt   <= '0;
            r_state <= FT_IDLE;
          end
        end
      end
    end
  end

  assign o_cnt    = r_cnt;
  assign o_active = (r_state == FT_RUN);
  assign o_tick   = r_tick;

endmodule

// File: rtl/frame_timer.sv
// Multi-channel frame timer: shared prescaler, configuration write decode and count readback.
// Each channel slice owns its own buffer, mode and FSM.
module frame_timer
  import frame_timer_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 32,
  parameter int DATA_W   = 8,
  parameter int PRESC_W  = 8,
  localparam int CH_W    = ft_idx_w(CHANNELS),
  localparam int BYTE_W  = ft_idx_w(CNT_W / DATA_W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en_in,
  input  logic [1:0]          wr_kind_in,
  input  logic [CH_W-1:0]     wr_ch_in,
  input  logic [BYTE_W-1:0]   wr_byte_in,
  input  logic [DATA_W-1:0]   wr_data_in,
  input  logic [CHANNELS-1:0] start_in,
  input  logic [CHANNELS-1:0] stop_in,
  input  logic [CHANNELS-1:0] pause_in,
  input  logic [CH_W-1:0]     rd_ch_in,
  output logic [CNT_W-1:0]    cnt_out,
  output logic [CHANNELS-1:0] active_out,
  output logic [CHANNELS-1:0] tick_out
);

  logic [PRESC_W-1:0]  r_presc_reg;
  logic [PRESC_W-1:0]  r_presc_cnt;
  logic                w_step;
  logic                w_wr_presc;
  logic [CHANNELS-1:0] w_wr_reload;
  logic [CHANNELS-1:0] w_wr_mode;
  logic [CNT_W-1:0]    w_cnt [CHANNELS];

  assign w_step     = (r_presc_cnt == r_presc_reg);
  assign w_wr_presc = wr_en_in && (wr_kind_in == FT_WR_PRESC);

  // Rewriting the divider also restarts its phase so the first period is predictable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc_reg <= '0;
      r_presc_cnt <= '0;
    end else if (w_wr_presc) begin
      r_presc_reg <= PRESC_W'(wr_data_in);
      r_presc_cnt <= '0;
    end else if (w_step) begin
      r_presc_cnt <= '0;
    end else begin
      r_presc_cnt <= r_presc_cnt + PRESC_W'(1);
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign w_wr_reload[g] = wr_en_in && (wr_kind_in == FT_WR_RELOAD) && (wr_ch_in == CH_W'(g));
    assign w_wr_mode[g]   = wr_en_in && (wr_kind_in == FT_WR_MODE)   && (wr_ch_in == CH_W'(g));

    frame_timer_ch #(
      .CNT_W  (CNT_W),
      .DATA_W (DATA_W),
      .BYTE_W (BYTE_W)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .i_wr_reload (w_wr_reload[g]),
      .i_wr_byte   (wr_byte_in),
      .i_wr_data   (wr_data_in),
      .i_wr_mode   (w_wr_mode[g]),
      .i_mode_bit  (wr_data_in[0]),
      .i_start     (start_in[g]),
      .i_stop      (stop_in[g]),
      .i_pause     (pause_in[g]),
      .i_step      (w_step),
      .o_cnt       (w_cnt[g]),
      .o_active    (active_out[g]),
      .o_tick      (tick_out[g])
    );
  end

  // Unpopulated channel indices read back as zero.
  always_comb begin
    cnt_out = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (rd_ch_in == CH_W'(i)) begin
        cnt_out = w_cnt[i];
      end
    end
  end

endmodule
